regfile_wb_arbiter: RTL

//  Sequences the single write port of the 32x32 register file. After reset it sweeps
//  x0..x31 to zero, then arbitrates N writeback requesters (ALU, load, CSR, ...) round-robin.
//  Its registered outputs drive the register file RegWrite/rd/Write_data directly.

---
 rtl/regfile_wb_arbiter_if.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bundle: per-requester valid/ready, dest reg and data, plus pipeline stall.
// No storage; purely a wiring bundle.
// Ready is driven by the arbiter side; requesters hold valid/rd/data until accepted.
interface regfile_wb_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_rd;
  logic [N_REQ*XLEN-1:0]   req_data;
  logic                    wb_stall;

  modport master (
    output req_valid, req_rd, req_data, wb_stall,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_rd, req_data, wb_stall,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port sequencer: zero sweep of all registers, then round-robin writeback arbitration.
// Latency: accepted request appears on RegWrite/rd/Write_data one cycle after the handshake.
// Backpressure: req_ready is low during the sweep and while wb_stall is high; no buffering.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8,
  localparam int GW    = $clog2(N_REQ),
  localparam int SW    = GW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_arbiter_if.slave bus,
  output logic               RegWrite,
  output logic [ADDR_W-1:0]  rd,
  output logic [XLEN-1:0]    Write_data,
  output logic [GW-1:0]      grant_id,
  output logic               init_done,
  output logic [CNT_W-1:0]   conflict_cnt
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] init_cnt;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     win;
  logic              win_vld;
  logic [SW-1:0]     sum;
  logic              hs;
  logic              last_init;
  logic [ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]   win_data;

  assign last_init = (init_cnt == {ADDR_W{1'b1}});
  assign win_rd    = bus.req_rd[win*ADDR_W +: ADDR_W];
  assign win_data  = bus.req_data[win*XLEN +: XLEN];
  assign hs        = |(bus.req_valid & bus.req_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  // Next state: the sweep ends after the last register address is written; RUN is terminal
  always_comb begin
    state_nx = state;
    if (state == S_INIT && last_init) state_nx = S_RUN;
  end

  // Round-robin search starting at rr_ptr, wrapping modulo N_REQ
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      if (!win_vld && bus.req_valid[sum[GW-1:0]]) begin
        win_vld = 1'b1;
        win     = sum[GW-1:0];
      end
    end
  end

  // Only the winner sees ready, and only in RUN without stall
  always_comb begin
    bus.req_ready = '0;
    if (state == S_RUN && !bus.wb_stall && win_vld) bus.req_ready[win] = 1'b1;
  end

  // Write-port outputs: sweep writes in INIT, accepted requests in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt   <= '0;
      rr_ptr     <= '0;
      RegWrite   <= 1'b0;
      rd         <= '0;
      Write_data <= '0;
      grant_id   <= '0;
      init_done  <= 1'b0;
    end else if (state == S_INIT) begin
      RegWrite   <= 1'b1;
      rd         <= init_cnt;
      Write_data <= '0;
      init_cnt   <= init_cnt + 1'b1;
      if (last_init) init_done <= 1'b1;
    end else if (hs) begin
      // x0 writes complete the handshake but never assert the write enable
      RegWrite   <= (win_rd != '0);
      rd         <= win_rd;
      Write_data <= win_data;
      grant_id   <= win;
      rr_ptr     <= (win == GW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  // Saturating contention counter, counted in RUN regardless of stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (state == S_RUN && $countones(bus.req_valid) > 1 &&
                 conflict_cnt != {CNT_W{1'b1}}) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
